// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcodes, IR fields, state encoding and alu_op indices
package cpu_defs_pkg;

  localparam int OPC_W    = 5;
  localparam int RF_W     = 4;
  localparam int NUM_REGS = 16;
  localparam int ALU_W    = 13;

  // IR field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'b10010;

  // alu_op bit indices
  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  // Step-sequence family an opcode belongs to
  typedef enum logic [1:0] {
    CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_BAD
  } op_class_t;

  function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
      OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL: op_class = CLS_ALU3;
      OPC_MUL, OPC_DIV:                    op_class = CLS_MULDIV;
      OPC_NEG, OPC_NOT:                    op_class = CLS_UNARY;
      default:                             op_class = CLS_BAD;
    endcase
  endfunction

  function automatic logic [ALU_W-1:0] alu_onehot(input logic [OPC_W-1:0] opc);
    alu_onehot = '0;
    case (opc)
      OPC_AND:  alu_onehot[ALU_AND]  = 1'b1;
      OPC_OR:   alu_onehot[ALU_OR]   = 1'b1;
      OPC_ADD:  alu_onehot[ALU_ADD]  = 1'b1;
      OPC_SUB:  alu_onehot[ALU_SUB]  = 1'b1;
      OPC_MUL:  alu_onehot[ALU_MUL]  = 1'b1;
      OPC_DIV:  alu_onehot[ALU_DIV]  = 1'b1;
      OPC_SHR:  alu_onehot[ALU_SHR]  = 1'b1;
      OPC_SHRA: alu_onehot[ALU_SHRA] = 1'b1;
      OPC_SHL:  alu_onehot[ALU_SHL]  = 1'b1;
      OPC_ROR:  alu_onehot[ALU_ROR]  = 1'b1;
      OPC_ROL:  alu_onehot[ALU_ROL]  = 1'b1;
      OPC_NEG:  alu_onehot[ALU_NEG]  = 1'b1;
      OPC_NOT:  alu_onehot[ALU_NOT]  = 1'b1;
      default:  alu_onehot = '0;
    endcase
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// rtl/reg_field_decoder.sv - register field to one-hot select with enable
module reg_field_decoder
  import cpu_defs_pkg::*;
(
  input  logic [RF_W-1:0]     i_field,
  input  logic                i_en,
  output logic [NUM_REGS-1:0] o_onehot
);

  // One-hot of the field when enabled, all-zero otherwise
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_field] = 1'b1;
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - hardwired fetch + ALU instruction control-step sequencer
module alu_instr_sequencer
  import cpu_defs_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [ALU_W-1:0]    alu_op,
  output logic                done,
  output logic                illegal
);

  state_t            r_state;
  state_t            w_next_state;
  state_t            w_after_done;
  logic              r_illegal;
  op_class_t         w_cls;
  logic [ALU_W-1:0]  w_alu;
  logic [RF_W-1:0]   w_ra, w_rb, w_rc;
  logic [RF_W-1:0]   w_rout_sel, w_rin_sel;
  logic              w_rout_en, w_rin_en;
  logic              w_bad_t3;
  logic              w_unused_ir_bits;

  // Fields are only meaningful from T3 onward; ir is held stable until done
  assign w_cls  = op_class(ir[OPC_MSB:OPC_LSB]);
  assign w_alu  = alu_onehot(ir[OPC_MSB:OPC_LSB]);
  assign w_ra   = ir[RA_MSB:RA_LSB];
  assign w_rb   = ir[RB_MSB:RB_LSB];
  assign w_rc   = ir[RC_MSB:RC_LSB];
  assign w_unused_ir_bits = ^ir[RC_LSB-1:0];

  assign w_bad_t3     = (r_state == ST_T3) && (w_cls == CLS_BAD);
  assign w_after_done = run ? ST_T0 : ST_IDLE;
  assign illegal      = r_illegal | w_bad_t3;

  // State register and sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_bad_t3) r_illegal <= 1'b1;
    end
  end

  // Next-state: fixed fetch, then a per-class tail; done steps chain straight to T0 when run is high
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (run) w_next_state = ST_T0;
      ST_T0:   w_next_state = ST_T1;
      ST_T1:   w_next_state = ST_T2;
      ST_T2:   w_next_state = ST_T3;
      ST_T3:   w_next_state = (w_cls == CLS_BAD) ? ST_HALT : ST_T4;
      ST_T4:   w_next_state = (w_cls == CLS_UNARY) ? w_after_done : ST_T5;
      ST_T5:   w_next_state = (w_cls == CLS_MULDIV) ? ST_T6 : w_after_done;
      ST_T6:   w_next_state = w_after_done;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Step strobes decoded from the current state (and the IR class in T3..T6)
  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0;
    Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; done = 1'b0;
    alu_op = '0;
    w_rout_en = 1'b0; w_rout_sel = '0;
    w_rin_en = 1'b0; w_rin_sel = '0;
    case (r_state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (w_cls)
          CLS_ALU3:   begin w_rout_en = 1'b1; w_rout_sel = w_rb; Yin = 1'b1; end
          CLS_MULDIV: begin w_rout_en = 1'b1; w_rout_sel = w_ra; Yin = 1'b1; end
          CLS_UNARY:  begin w_rout_en = 1'b1; w_rout_sel = w_rb; alu_op = w_alu; Zin = 1'b1; end
          default:    ;
        endcase
      end
      ST_T4: begin
        case (w_cls)
          CLS_ALU3:   begin w_rout_en = 1'b1; w_rout_sel = w_rc; alu_op = w_alu; Zin = 1'b1; end
          CLS_MULDIV: begin w_rout_en = 1'b1; w_rout_sel = w_rb; alu_op = w_alu; Zin = 1'b1; end
          CLS_UNARY:  begin Zlowout = 1'b1; w_rin_en = 1'b1; w_rin_sel = w_ra; done = 1'b1; end
          default:    ;
        endcase
      end
      ST_T5: begin
        case (w_cls)
          CLS_ALU3:   begin Zlowout = 1'b1; w_rin_en = 1'b1; w_rin_sel = w_ra; done = 1'b1; end
          CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          default:    ;
        endcase
      end
      ST_T6: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  reg_field_decoder u_rout_dec (
    .i_field  (w_rout_sel),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

  reg_field_decoder u_rin_dec (
    .i_field  (w_rin_sel),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

endmodule
